// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkg
// Purpose  : Shared sample format, recorder state encoding and mono conversion.
// Revision : 1.0
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W = 19;
    localparam int SHIFT    = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RECORD = 2'd2,
        DONE   = 2'd3
    } rec_state_t;

    // Playback restores the stored sample with <<SHIFT, so this is its inverse.
    function automatic logic [SAMPLE_W-1:0] mono_to_sample(
        input logic [31:0] left,
        input logic [31:0] right,
        input int unsigned shift
    );
        logic signed [32:0] mix;
        logic signed [31:0] mono;
        mix  = $signed({left[31], left}) + $signed({right[31], right});
        mono = 32'(mix >>> 1);
        return SAMPLE_W'(mono >>> shift);
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_sample_conv.sv
`default_nettype none
// ============================================================================
// Module   : audio_sample_conv
// Purpose  : Down-mix L/R to mono, scale to the stored sample width, magnitude.
// Revision : 1.0
// ============================================================================
module audio_sample_conv #(
    parameter int SAMPLE_W = 19,
    parameter int SHIFT    = 14
) (
    input  logic [31:0]         left,
    input  logic [31:0]         right,
    output logic [SAMPLE_W-1:0] sample,
    output logic [SAMPLE_W:0]   magnitude
);

    logic signed [32:0]     w_mix;
    logic signed [31:0]     w_mono;
    logic signed [SAMPLE_W:0] w_ext;

    assign w_mix  = $signed({left[31], left}) + $signed({right[31], right});
    assign w_mono = 32'(w_mix >>> 1);
    assign sample = SAMPLE_W'(w_mono >>> SHIFT);

    // One extra bit so the most-negative sample still has a representable magnitude.
    assign w_ext     = $signed({sample[SAMPLE_W-1], sample});
    assign magnitude = w_ext[SAMPLE_W] ? (SAMPLE_W+1)'(-w_ext) : w_ext;

endmodule
`default_nettype wire

// File: rtl/audio_recorder.sv
`default_nettype none
// ============================================================================
// Module   : audio_recorder
// Purpose  : Drains the audio-in FIFO, triggers on level and records mono samples to RAM.
// Revision : 1.0
// ============================================================================
module audio_recorder #(
    parameter int                  SAMPLE_W    = 19,
    parameter int                  SHIFT       = 14,
    parameter int                  ADDR_W      = 16,
    parameter int                  MAX_SAMPLES = 50161,
    parameter int                  DECIM       = 1,
    parameter logic [SAMPLE_W-1:0] THRESH      = SAMPLE_W'(2048)
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                audio_in_available,
    input  logic [31:0]         left_channel_audio_in,
    input  logic [31:0]         right_channel_audio_in,
    output logic                read_audio_in,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SAMPLE_W-1:0] wr_data,
    output logic                armed,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   length
);

    import audio_pkg::*;

    localparam int                CNT_W     = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DECIM - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_SAMPLES - 1);

    rec_state_t          r_state;
    rec_state_t          w_state_nxt;
    logic [CNT_W-1:0]    r_decim_cnt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W-1:0]   r_length;
    logic [SAMPLE_W-1:0] r_wr_data;
    logic                r_wr_en;
    logic [SAMPLE_W-1:0] w_sample;
    logic [SAMPLE_W:0]   w_magnitude;
    logic                w_capture;
    logic                w_kept;
    logic                w_write;
    logic                w_arm;
    logic                w_clear_len;

    audio_sample_conv #(
        .SAMPLE_W (SAMPLE_W),
        .SHIFT    (SHIFT)
    ) u_conv (
        .left      (left_channel_audio_in),
        .right     (right_channel_audio_in),
        .sample    (w_sample),
        .magnitude (w_magnitude)
    );

    // The FIFO is drained in every state so it can never overflow.
    assign read_audio_in = audio_in_available;
    assign w_capture     = (r_state == ARMED) || (r_state == RECORD);
    assign w_kept        = audio_in_available && w_capture && (r_decim_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_arm       = 1'b0;
        w_clear_len = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = ARMED;
                    w_arm       = 1'b1;
                end
            end
            ARMED: begin
                if (stop) begin
                    w_state_nxt = DONE;
                    w_clear_len = 1'b1;
                end else if (w_kept && (w_magnitude >= {1'b0, THRESH})) begin
                    w_state_nxt = RECORD;
                    w_write     = 1'b1;
                end
            end
            RECORD: begin
                if (stop) begin
                    w_state_nxt = DONE;
                end else if (w_kept) begin
                    w_write = 1'b1;
                    if (r_ptr == ADDR_LAST) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = ARMED;
                    w_arm       = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_decim_cnt <= '0;
            r_ptr       <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_length    <= '0;
        end else begin
            r_wr_en <= w_write;
            if (w_arm) begin
                r_decim_cnt <= '0;
                r_ptr       <= '0;
                r_wr_addr   <= '0;
            end else begin
                if (audio_in_available && w_capture) begin
                    r_decim_cnt <= (r_decim_cnt == CNT_LAST) ? '0 : r_decim_cnt + 1'b1;
                end
                if (w_write) begin
                    r_wr_addr <= r_ptr;
                    r_wr_data <= w_sample;
                    r_ptr     <= r_ptr + 1'b1;
                end
            end
            // Length trails the write strobe, so a restart keeps the old value until data lands.
            if (w_clear_len) begin
                r_length <= '0;
            end else if (r_wr_en) begin
                r_length <= r_wr_addr + 1'b1;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign length  = r_length;
    assign armed   = (r_state == ARMED);
    assign busy    = (r_state == RECORD);
    assign done    = (r_state == DONE);

endmodule
`default_nettype wire

// File: doc/audio_recorder.md
Name: audio_recorder

Overview:
- Capture-side counterpart to the ROM playback path.
- Drains the Audio_Controller input FIFO and down-mixes left/right to mono.
- Decimates, then converts each kept sample to the 19-bit signed sample format used by the playback ROM (playback restores it with <<14).
- Writes kept samples sequentially into a single-port RAM and reports the recorded length, so the same data can later be read back.
- Sits between Audio_Controller (read side) and a RAM instance, controlled by start/stop pulses from the top level.

Parameters:
- SAMPLE_W, 19, width of stored sample.
- SHIFT, 14, arithmetic right shift applied to the mono mix (inverse of playback <<14).
- ADDR_W, 16, RAM address width.
- MAX_SAMPLES, 50161, samples written before auto-stop (must be <= 2**ADDR_W).
- DECIM, 1, keep every DECIM-th FIFO sample (1 = 48 kHz).
- THRESH, 19'd2048, absolute sample level that triggers recording from ARMED.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: arm a new capture.
- stop  in  1  one-cycle pulse: end capture.
- audio_in_available  in  1  Audio_Controller FIFO non-empty.
- left_channel_audio_in  in  32  signed, valid while audio_in_available is high.
- right_channel_audio_in  in  32  signed, valid while audio_in_available is high.
- read_audio_in  out  1  FIFO pop, combinational.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM address.
- wr_data  out  SAMPLE_W  RAM data.
- armed  out  1  state == ARMED.
- busy  out  1  state == RECORD.
- done  out  1  state == DONE.
- length  out  ADDR_W  number of samples written by the last capture.

Behaviour:
- Reset: state IDLE; wr_en, wr_addr, wr_data, length, decimation counter all 0; armed, busy, done 0. Reset mid-capture aborts it; length returns to 0.
- FIFO handshake:
  - read_audio_in = audio_in_available in every state, including IDLE and DONE, so the FIFO never overflows.
  - Data is sampled in the same cycle read_audio_in is high; at most one pop per cycle.
- Sample conversion:
  - mono = (L + R) >>> 1, computed at 33 bits, then narrowed to 32 bits.
  - s = mono >>> SHIFT, truncated to SAMPLE_W bits (two's complement).
  - |s| is computed on SAMPLE_W+1 bits, so the most-negative value is handled.
- Decimation:
  - A counter counts 0..DECIM-1 on each pop in ARMED or RECORD.
  - A sample is "kept" when the counter is 0.
  - The counter clears on entry to ARMED.
- State machine IDLE/ARMED/RECORD/DONE:
  - IDLE: start -> ARMED.
  - ARMED: a kept sample with |s| >= THRESH -> RECORD, and that sample is written at address 0. stop -> DONE with length = 0.
  - RECORD: every kept sample is written. After the write at address MAX_SAMPLES-1 -> DONE. stop -> DONE, and a kept sample arriving in the same cycle is NOT written.
  - DONE: holds length; start -> ARMED (wr_addr cleared, length held until first write).
- Write timing:
  - wr_en, wr_addr and wr_data are registered, so wr_en is high exactly one cycle after the pop that produced the sample.
  - wr_addr increments after each write.
  - length = count of writes, updated with the wr_en cycle.
- Simultaneous start+stop: start wins in IDLE/DONE; stop wins in ARMED/RECORD. start is ignored while ARMED/RECORD.
- The RAM never receives an address >= MAX_SAMPLES; there is no wrap-around.

Decomposition:
- Package audio_pkg holds:
  - SAMPLE_W, SHIFT and the state enum IDLE/ARMED/RECORD/DONE;
  - the function mono_to_sample (mix, shift, truncate), shared with any future playback-from-RAM block.
- One natural sub-module: audio_sample_conv (combinational mix/shift/abs). The FSM and counters stay in audio_recorder.

Test Plan:
- Reset while idle with FIFO active (audio_in_available held high for 10 cycles) -> read_audio_in high all 10 cycles, wr_en never asserted, length = 0.
- start, then L = R = 32'd16384 (s = 1, below THRESH) for 20 pops -> stays ARMED, no writes. Then L = R = 32'd100000000 (s = 6103) -> RECORD; wr_en one cycle later with wr_addr = 0, wr_data = 19'd6103.
- Negative trigger: L = -32'd100000000, R = -32'd100000000 -> |s| = 6104 >= THRESH, wr_data = -19'd6104.
- MAX_SAMPLES = 8, DECIM = 3: 30 loud pops after trigger -> exactly 8 writes at addresses 0..7, every third pop kept; DONE, length = 8, no write at addr 8.
- stop asserted in the same cycle as a kept sample at addr 5 -> DONE, length = 5, no 6th write. Then start+stop together in DONE -> ARMED.
- Reset asserted mid-RECORD at addr 3 -> next cycle IDLE, wr_en = 0, length = 0. A subsequent capture starts again at wr_addr 0.
